segment_animator_multi: RTL and testbench

//   Parametrised multi-digit 7-segment animator. Accepts {digit, glyph, mode, delay}

---
 rtl/segment_animator_multi_if.sv | 24 ++
 rtl/segment_animator_multi.sv | 166 ++++++++++++++++
 tb/tb_segment_animator_multi.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/segment_animator_multi_if.sv
// Request channel into the segment animator: one {digit, glyph, mode, delay}
// command per valid/ready handshake.
interface segment_animator_multi_if #(
  parameter int DIG_W   = 2,
  parameter int SEGS    = 7,
  parameter int DELAY_W = 6
);
  logic               req_valid;
  logic               req_ready;
  logic [DIG_W-1:0]   req_digit;
  logic [SEGS-1:0]    req_glyph;
  logic [1:0]         req_mode;
  logic [DELAY_W-1:0] req_delay;

  modport master (
    output req_valid, req_digit, req_glyph, req_mode, req_delay,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_digit, req_glyph, req_mode, req_delay,
    output req_ready
  );
endinterface

// File: rtl/segment_animator_multi.sv
// Multi-digit 7-segment animator: reveals or erases one digit's segments one at a
// time, paced by rising edges of a slow tick strobe.
module segment_animator_multi #(
  parameter int NUM_DIGITS = 4,
  parameter int SEGS       = 7,
  parameter int DELAY_W    = 6,
  parameter int DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       tick,
  segment_animator_multi_if.slave    req,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_DIGITS*SEGS-1:0] seg_out
);
  localparam int IDX_W = (SEGS > 1) ? $clog2(SEGS) : 1;
  localparam int REM_W = $clog2(SEGS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_WAIT, ST_DONE} state_e;
  typedef enum logic [1:0] {
    MODE_REVEAL_FWD = 2'b00,
    MODE_REVEAL_REV = 2'b01,
    MODE_ERASE_FWD  = 2'b10,
    MODE_INSTANT    = 2'b11
  } mode_e;

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [REM_W-1:0]                 rem_q, rem_d;
  logic [DELAY_W-1:0]               timer_q, timer_d;
  logic [SEGS-1:0]                  glyph_q;
  logic [DIG_W-1:0]                 digit_q;
  mode_e                            mode_q;
  logic [DELAY_W-1:0]               delay_q;
  logic [NUM_DIGITS-1:0][SEGS-1:0]  seg_q, seg_d;
  logic                             tick_prev_q;

  logic               accept;
  logic               tick_edge;
  logic               digit_oob;
  logic               hit;
  logic [SEGS-1:0]    idx_onehot;
  logic [DELAY_W-1:0] delay_eff;
  mode_e              req_mode_e;

  assign req_mode_e = mode_e'(req.req_mode);
  assign accept     = req.req_valid & req.req_ready;
  assign tick_edge  = tick & ~tick_prev_q;
  assign digit_oob  = int'(req.req_digit) >= NUM_DIGITS;
  assign delay_eff  = (delay_q == '0) ? DELAY_W'(1) : delay_q;
  assign hit        = |(glyph_q & idx_onehot);
  assign seg_out    = seg_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    idx_onehot = '0;
    for (int i = 0; i < SEGS; i++) begin
      if (int'(idx_q) == i) idx_onehot[i] = 1'b1;
    end
  end

  // State register plus datapath registers; tick history runs even when frozen.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every register, segment bank included, clears asynchronously on reset.
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      rem_q       <= '0;
      timer_q     <= '0;
      glyph_q     <= '0;
      digit_q     <= '0;
      mode_q      <= MODE_REVEAL_FWD;
      delay_q     <= '0;
      seg_q       <= '0;
      tick_prev_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      tick_prev_q <= tick;
      if (enable) begin
        state_q <= state_d;
        idx_q   <= idx_d;
        rem_q   <= rem_d;
        timer_q <= timer_d;
        seg_q   <= seg_d;
        if (accept) begin
          glyph_q <= req.req_glyph;
          digit_q <= req.req_digit;
          mode_q  <= req_mode_e;
          delay_q <= req.req_delay;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (digit_oob || req_mode_e == MODE_INSTANT) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (rem_q == '0)                state_d = ST_DONE;
        else if (hit)                   state_d = ST_WAIT;
        else if (rem_q == REM_W'(1))    state_d = ST_DONE;
      end
      ST_WAIT: begin
        if (tick_edge && timer_q == DELAY_W'(1)) state_d = ST_SCAN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: scan index, remaining count, step timer and segment bank.
  always_comb begin
    seg_d   = seg_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rem_d = REM_W'(SEGS);
          idx_d = (req_mode_e == MODE_REVEAL_REV) ? IDX_W'(SEGS - 1) : '0;
          for (int d = 0; d < NUM_DIGITS; d++) begin
            if (int'(req.req_digit) == d) begin
              if (req_mode_e == MODE_INSTANT)
                seg_d[d] = req.req_glyph;
              else if (req_mode_e != MODE_ERASE_FWD)
                seg_d[d] = '0;
            end
          end
        end
      end
      ST_SCAN: begin
        if (rem_q != '0) begin
          rem_d = rem_q - 1'b1;
          idx_d = (mode_q == MODE_REVEAL_REV) ? idx_q - 1'b1 : idx_q + 1'b1;
          if (hit) begin
            timer_d = delay_eff;
            for (int d = 0; d < NUM_DIGITS; d++) begin
              if (int'(digit_q) == d) begin
                if (mode_q == MODE_ERASE_FWD) seg_d[d] = seg_q[d] & ~idx_onehot;
                else                          seg_d[d] = seg_q[d] | idx_onehot;
              end
            end
          end
        end
      end
      ST_WAIT: begin
        if (tick_edge && timer_q != DELAY_W'(1)) timer_d = timer_q - 1'b1;
      end
      default: ;
    endcase
  end

  // Ready is forced low while reset is held, independent of the frozen state.
  always_comb begin
    busy          = (state_q != ST_IDLE);
    done          = enable & (state_q == ST_DONE);
    req.req_ready = reset_n & enable & (state_q == ST_IDLE);
  end
endmodule

// File: tb/tb_segment_animator_multi.sv
// Directed bench for segment_animator_multi with a scoreboard of expected
// segment banks, compared whenever the DUT pulses done.
module tb_segment_animator_multi;
  localparam int ND = 4;
  localparam int SG = 7;
  localparam int DW = 6;
  localparam int GW = 3;

  typedef struct {
    string       tag;
    logic [27:0] seg;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        tick;
  logic        busy;
  logic        done;
  logic [27:0] seg_out;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];
  logic [SG-1:0] mdl [ND];

  segment_animator_multi_if #(.DIG_W(GW), .SEGS(SG), .DELAY_W(DW)) rif ();

  segment_animator_multi #(
    .NUM_DIGITS(ND), .SEGS(SG), .DELAY_W(DW), .DIG_W(GW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (tick),
    .req     (rif),
    .busy    (busy),
    .done    (done),
    .seg_out (seg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  function automatic logic [27:0] packed_mdl();
    logic [27:0] r;
    r = '0;
    for (int d = 0; d < ND; d++) r[d*SG +: SG] = mdl[d];
    return r;
  endfunction

  function automatic void apply(input int d, input logic [SG-1:0] g, input logic [1:0] m);
    if (d < ND) begin
      case (m)
        2'b10:   mdl[d] = mdl[d] & ~g;
        default: mdl[d] = g;
      endcase
    end
  endfunction

  // Drive one request, push its expected final bank, return just after the accept edge.
  task automatic send(input string tag, input int d, input logic [SG-1:0] g,
                      input logic [1:0] m, input logic [DW-1:0] dl);
    int i;
    apply(d, g, m);
    sb.push_back('{tag, packed_mdl()});
    rif.req_digit = GW'(d);
    rif.req_glyph = g;
    rif.req_mode  = m;
    rif.req_delay = dl;
    rif.req_valid = 1'b1;
    i = 0;
    while (!rif.req_ready && i < 20) begin
      step();
      i++;
    end
    check({tag, "_rdy"}, 32'(rif.req_ready), 32'd1);
    step();
    rif.req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    exp_t e;
    i = 0;
    while (!done && i < budget) begin
      step();
      i++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_seg"}, 32'(seg_out), 32'(e.seg));
    end else begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end
    step();
    check({tag, "_pulse1"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n       = 1'b0;
    enable        = 1'b1;
    tick          = 1'b0;
    rif.req_valid = 1'b0;
    rif.req_digit = '0;
    rif.req_glyph = '0;
    rif.req_mode  = '0;
    rif.req_delay = '0;
    for (int d = 0; d < ND; d++) mdl[d] = '0;

    step();
    step();
    check("rst_seg", 32'(seg_out), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(rif.req_ready), 32'd0);
    reset_n = 1'b1;
    step();
    check("idle_ready", 32'(rif.req_ready), 32'd1);

    // Reveal forward, delay 3
    send("t1", 0, 7'b0000101, 2'b00, 6'd3);
    check("t1_busy", 32'(busy), 32'd1);
    step();
    check("t1_bit0", 32'(seg_out), 32'h1);
    pulse();
    pulse();
    check("t1_hold", 32'(seg_out), 32'h1);
    pulse();
    step();
    check("t1_bit2", 32'(seg_out), 32'h5);
    pulse();
    pulse();
    check("t1_nodone", 32'(done), 32'd0);
    pulse();
    wait_done("t1", 10);

    // Reveal reverse, delay 0 treated as 1
    send("t2", 2, 7'b1000001, 2'b01, 6'd0);
    step();
    check("t2_bit6", 32'(seg_out), 32'h100005);
    pulse();
    repeat (5) step();
    check("t2_bit0", 32'(seg_out), 32'h104005);
    pulse();
    wait_done("t2", 4);

    // Instant fill then erase forward
    send("t3_fill", 1, 7'h7F, 2'b11, 6'd0);
    wait_done("t3_fill", 3);
    send("t3", 1, 7'b0000011, 2'b10, 6'd1);
    check("t3_keep", 32'(seg_out), 32'h107F85);
    step();
    check("t3_clr0", 32'(seg_out), 32'h107F05);
    pulse();
    check("t3_clr1", 32'(seg_out), 32'h107E05);
    pulse();
    wait_done("t3", 8);

    // Instant write and out-of-range digit
    send("t4", 3, 7'b0110000, 2'b11, 6'd0);
    check("t4_inst", 32'(seg_out), 32'h6107E05);
    wait_done("t4", 2);
    send("t4_oob", 5, 7'h7F, 2'b11, 6'd0);
    wait_done("t4_oob", 3);

    // Held request during busy, freeze with enable low
    send("t5", 0, 7'b0000001, 2'b00, 6'd2);
    apply(2, 7'b0000000, 2'b00);
    sb.push_back('{"t6_zero", packed_mdl()});
    rif.req_digit = GW'(2);
    rif.req_glyph = '0;
    rif.req_mode  = 2'b00;
    rif.req_delay = 6'd0;
    rif.req_valid = 1'b1;
    check("t5_ready_busy", 32'(rif.req_ready), 32'd0);
    step();
    check("t5_bit0", 32'(seg_out), 32'h6107E01);
    enable = 1'b0;
    pulse();
    pulse();
    tick = 1'b1;
    step();
    check("t5_frz_seg", 32'(seg_out), 32'h6107E01);
    check("t5_frz_busy", 32'(busy), 32'd1);
    check("t5_frz_done", 32'(done), 32'd0);
    check("t5_frz_ready", 32'(rif.req_ready), 32'd0);
    enable = 1'b1;
    step();
    tick = 1'b0;
    step();
    pulse();
    check("t5_resume1", 32'(busy), 32'd1);
    check("t5_resume_nodone", 32'(done), 32'd0);
    pulse();
    wait_done("t5", 12);
    check("t5_ready_idle", 32'(rif.req_ready), 32'd1);
    step();
    rif.req_valid = 1'b0;
    check("t6_zero_clr", 32'(seg_out), 32'h6003E01);
    repeat (6) step();
    check("t6_early", 32'(done), 32'd0);
    wait_done("t6_zero", 1);

    // Asynchronous reset during WAIT
    send("t6_rst", 3, 7'b0000001, 2'b00, 6'd5);
    step();
    check("t6_bit0", 32'(seg_out), 32'h203E01);
    pulse();
    reset_n = 1'b0;
    #1;
    check("t6_rst_seg", 32'(seg_out), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ready", 32'(rif.req_ready), 32'd0);
    void'(sb.pop_back());
    for (int d = 0; d < ND; d++) mdl[d] = '0;
    step();
    reset_n = 1'b1;
    step();
    check("t6_post_busy", 32'(busy), 32'd0);
    send("t7", 1, 7'h55, 2'b11, 6'd0);
    wait_done("t7", 3);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
